// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM state encoding,
// default geometry and byte-lane select values.
package lsu_pkg;

  localparam int LSU_ADDR_WIDTH = 6;
  localparam int LSU_DATA_WIDTH = 16;
  localparam int BYTE_WIDTH     = 8;

  // Byte-address bit 0 selects the lane inside a 16-bit word.
  localparam logic LANE_LO = 1'b0;  // bits [7:0]
  localparam logic LANE_HI = 1'b1;  // bits [15:8]

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    RMW_WRITE = 2'd2,
    RSP       = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane helper: pulls one byte out of a word (zero-extended) for byte
// loads, and splices a byte into a word for the read-modify-write store.
module lsu_byte_lane
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = LSU_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] word_in,
  input  logic                  lane,
  input  logic [BYTE_WIDTH-1:0] byte_in,
  output logic [DATA_WIDTH-1:0] byte_ext,
  output logic [DATA_WIDTH-1:0] word_merged
);

  // Lane extract and lane merge share the same lane select.
  always_comb begin
    // NOTE: every output gets a default before the if, so no path leaves a
    // bit unassigned and no latch is inferred.
    byte_ext    = '0;
    word_merged = word_in;
    if (lane == LANE_HI) begin
      byte_ext[BYTE_WIDTH-1:0]                 = word_in[2*BYTE_WIDTH-1:BYTE_WIDTH];
      word_merged[2*BYTE_WIDTH-1:BYTE_WIDTH]   = byte_in;
    end else begin
      byte_ext[BYTE_WIDTH-1:0]                 = word_in[BYTE_WIDTH-1:0];
      word_merged[BYTE_WIDTH-1:0]              = byte_in;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit in front of a synchronous read-first data memory with a
// one-cycle read latency. Word stores complete in the accept cycle; loads
// return a response two cycles after acceptance; byte stores are done as a
// read followed by a merged write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = LSU_ADDR_WIDTH,
  parameter int DATA_WIDTH = LSU_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  // request channel
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic                  req_byte,
  input  logic [ADDR_WIDTH:0]   req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  // load response channel
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  // data memory port
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_di,
  input  logic [DATA_WIDTH-1:0] mem_do
);

  lsu_state_e state, state_next;

  // Fields captured at acceptance of a load or byte store.
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic                  lat_lane;
  logic [BYTE_WIDTH-1:0] lat_byte;
  logic                  lat_is_byte;

  logic                  accept;
  logic                  accept_word_store;
  logic [DATA_WIDTH-1:0] byte_ext;
  logic [DATA_WIDTH-1:0] word_merged;

  assign accept            = req_valid && req_ready;
  assign accept_word_store = accept && req_we && !req_byte;
  assign rsp_valid         = (state == RSP);

  lsu_byte_lane #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_byte_lane (
    .word_in     (mem_do),
    .lane        (lat_lane),
    .byte_in     (lat_byte),
    .byte_ext    (byte_ext),
    .word_merged (word_merged)
  );

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and memory port drive.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = lat_addr;
    mem_di     = req_wdata;
    unique case (state)
      IDLE: begin
        req_ready = !rst;
        if (req_valid && req_ready) begin
          mem_en   = 1'b1;
          mem_addr = req_addr[ADDR_WIDTH:1];
          if (req_we && !req_byte) begin
            // Word store writes straight through and stays ready.
            mem_we = 1'b1;
          end else if (req_we) begin
            // Byte store: this cycle reads the old word.
            state_next = RMW_WRITE;
          end else begin
            state_next = LOAD_WAIT;
          end
        end
      end
      LOAD_WAIT: begin
        state_next = RSP;
      end
      RMW_WRITE: begin
        mem_en     = 1'b1;
        mem_we     = 1'b1;
        mem_di     = word_merged;
        state_next = IDLE;
      end
      RSP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // Reset kills any memory access, including the write half of an RMW.
    if (rst) begin
      mem_en = 1'b0;
      mem_we = 1'b0;
    end
  end

  // Capture of request fields and registered load data.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_addr    <= '0;
      lat_lane    <= LANE_LO;
      lat_byte    <= '0;
      lat_is_byte <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      if (accept && !accept_word_store) begin
        lat_addr    <= req_addr[ADDR_WIDTH:1];
        lat_lane    <= req_addr[0];
        lat_byte    <= req_wdata[BYTE_WIDTH-1:0];
        lat_is_byte <= req_byte;
      end
      if (state == LOAD_WAIT) begin
        rsp_rdata <= lat_is_byte ? byte_ext : mem_do;
      end
    end
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters: ADDR_WIDTH, default 6, memory word-address width.
REQ-002 Parameters: DATA_WIDTH, default 16, memory word width; byte operations require DATA_WIDTH=16.
REQ-003 Ports: clk  in  1  sole clock, all logic on rising edge.
REQ-004 Ports: rst  in  1  reset, synchronous, active-high.
REQ-005 Ports: req_valid in 1 / req_ready out 1  request handshake; transfer on the cycle both are high.
REQ-006 Ports: req_we  in  1  1=store, 0=load.
REQ-007 Ports: req_byte  in  1  1=byte access, 0=word access.
REQ-008 Ports: req_addr  in  ADDR_WIDTH+1  byte address; word index = req_addr[ADDR_WIDTH:1]; bit0 selects lane (0 = [7:0], 1 = [15:8]).
REQ-009 Ports: req_wdata  in  DATA_WIDTH  store data; byte stores use [7:0].
REQ-010 Ports: rsp_valid out 1 / rsp_ready in 1 / rsp_rdata out DATA_WIDTH  load response handshake and data.
REQ-011 Ports: mem_en, mem_we out 1; mem_addr out ADDR_WIDTH; mem_di out DATA_WIDTH; mem_do in DATA_WIDTH  drive the synchronous data memory (read-first, one-cycle read latency).

Function
REQ-012 FSM states: IDLE, LOAD_WAIT, RMW_WRITE, RSP.
REQ-013 req_ready SHALL equal (state==IDLE && !rst).
REQ-014 Word store accepted: same cycle mem_en=1, mem_we=1, mem_addr=word index, mem_di=req_wdata; state stays IDLE; no response generated; throughput one per cycle.
REQ-015 Load accepted: same cycle mem_en=1, mem_we=0, mem_addr=word index; next state LOAD_WAIT.
REQ-016 LOAD_WAIT: mem_do is valid; register rsp_rdata (word load: mem_do; byte load: selected lane zero-extended); next state RSP; rsp_valid high in the cycle 2 cycles after acceptance.
REQ-017 RSP: rsp_valid=1, rsp_rdata stable; on rsp_ready=1 go to IDLE next cycle; otherwise hold indefinitely.
REQ-018 Byte store accepted: same cycle memory read of word index (mem_en=1, mem_we=0); latch lane, address, byte; next state RMW_WRITE.
REQ-019 RMW_WRITE: mem_en=1, mem_we=1, same mem_addr, mem_di = mem_do with the selected lane replaced by latched byte; next state IDLE; req_ready low exactly one cycle.
REQ-020 In all other cycles mem_en=0 and mem_we=0; mem_addr/mem_di don't-care.
REQ-021 Word loads/stores ignore req_addr[0].
REQ-022 Address wrap: none needed; byte address 2^(ADDR_WIDTH+1)-1 maps to the last word, upper lane.
REQ-023 mem_en/mem_we SHALL be forced 0 during any cycle rst is high, suppressing any in-flight write.

Reset
REQ-024 On rst: state=IDLE, rsp_valid=0, rsp_rdata=0, latched RMW fields=0; in-flight operations discarded without response.
REQ-025 First request may be accepted in the first cycle after rst deasserts.

Structure
REQ-026 Package lsu_pkg SHALL hold the state enum, ADDR_WIDTH/DATA_WIDTH defaults and lane-select constants.
REQ-027 One combinational sub-module lsu_byte_lane SHALL implement byte extract (zero-extend) and byte merge; the memory itself is instantiated outside this block.

Verification
REQ-028 Word store 0xBEEF @0x0A, then word load @0x0A -> mem_addr=5 both; rsp_rdata=0xBEEF, rsp_valid 2 cycles after load accept.
REQ-029 Word 5=0x1234; byte store 0xAB @0x0B -> read then write cycle, req_ready low 1 cycle, word 5=0xAB34; byte store 0xCD @0x0A -> 0xABCD.
REQ-030 Word 5=0xAB34; byte load @0x0B -> 0x00AB; byte load @0x0A -> 0x0034.
REQ-031 Load with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0; rsp_ready=1 -> IDLE next cycle, req_ready=1.
REQ-032 64 back-to-back word stores (word i = i) at one per cycle, req_ready constantly 1; loads @0x00 and @0x7F -> 0x0000 and 0x003F.
REQ-033 rst asserted in RMW_WRITE cycle of byte store 0xFF @0x01 to word 0=0x1234 -> mem_we never 1, word 0 stays 0x1234, rsp_valid=0, req_ready=1 after release.
